// File: rtl/mem_block_mover.sv
// Copies or fills a byte range of the data RAM on its own, one byte per WRITE
// cycle. Copy costs two cycles per byte (READ then WRITE); fill costs one.
module mem_block_mover #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] count_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;

  // Bus outputs are registered from the next-state view so they line up
  // with the state they describe.
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ren_q, ren_d;
  logic                wen_q, wen_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d = mode_i;
          src_d  = src_i;
          dst_d  = dst_i;
          rem_d  = len_i;
          cnt_d  = '0;
          if (len_i == '0)
            state_d = DONE;
          else
            state_d = mode_i ? WRITE : READ;
        end
      end
      READ: begin
        data_d  = mem_rdata_i;
        state_d = WRITE;
      end
      WRITE: begin
        dst_d = dst_q + ADDR_W'(1);
        if (!mode_q)
          src_d = src_q + ADDR_W'(1);
        rem_d = rem_q - ADDR_W'(1);
        cnt_d = cnt_q + ADDR_W'(1);
        if (rem_q == ADDR_W'(1))
          state_d = DONE;
        else
          state_d = mode_q ? WRITE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_d)
      READ: begin
        addr_d = src_d;
        ren_d  = 1'b1;
        busy_d = 1'b1;
      end
      WRITE: begin
        addr_d  = dst_d;
        wen_d   = 1'b1;
        busy_d  = 1'b1;
        wdata_d = mode_d ? src_d[DATA_W-1:0] : data_d;
      end
      DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Enables are cut by reset on the same cycle so an in-flight byte never lands.
  assign mem_ren_o   = ren_q & ~RST;
  assign mem_wen_o   = wen_q & ~RST;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign count_o     = cnt_q;

endmodule
